// File: rtl/fifo_sync.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync
// Brief    : Single-clock valid/ready FIFO, power-of-two depth, occupancy
//            count, almost-full/almost-empty flags and synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_sync #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 4,
  parameter int FLOPS_NOT_MEM = 0,
  parameter int ALMOST_FULL   = 3,
  parameter int ALMOST_EMPTY  = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_cg,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_wvalid,
  output logic                       o_wready,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_rvalid,
  input  logic                       i_rready,
  output logic [$clog2(DEPTH+1)-1:0] o_nEntries,
  output logic                       o_almostFull,
  output logic                       o_almostEmpty
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_PW = c_AW + 1;
  localparam int c_NW = $clog2(DEPTH+1);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("fifo_sync: DEPTH must be a power of two and >= 2");
    end
    if ((ALMOST_FULL < 1) || (ALMOST_FULL > DEPTH)) begin : g_bad_afull
      $error("fifo_sync: ALMOST_FULL must be in 1..DEPTH");
    end
    if ((ALMOST_EMPTY < 0) || (ALMOST_EMPTY > DEPTH - 1)) begin : g_bad_aempty
      $error("fifo_sync: ALMOST_EMPTY must be in 0..DEPTH-1");
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("fifo_sync: WIDTH must be >= 1");
    end
  endgenerate

  logic [c_PW-1:0]  r_wptr;
  logic [c_PW-1:0]  r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_empty;
  logic             w_full;
  logic             w_doWrite;
  logic             w_doRead;
  logic [c_PW-1:0]  w_wptrNext;
  logic [c_PW-1:0]  w_rptrNext;
  logic [c_NW-1:0]  w_count;

  // Wrap bit distinguishes full from empty when the index bits coincide.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]) &&
                   (r_wptr[c_AW] != r_rptr[c_AW]);

  assign o_wready  = i_cg && !w_full;
  assign o_rvalid  = i_cg && !w_empty;
  assign w_doWrite = o_wready && i_wvalid;
  assign w_doRead  = o_rvalid && i_rready;

  // A flush lands the read pointer on the post-write pointer, discarding
  // any word accepted in the same cycle.
  assign w_wptrNext = w_doWrite ? (r_wptr + c_PW'(1)) : r_wptr;
  assign w_rptrNext = (i_flush && i_cg) ? w_wptrNext :
                      (w_doRead ? (r_rptr + c_PW'(1)) : r_rptr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_wptr <= w_wptrNext;
      r_rptr <= w_rptrNext;
    end
  end

  generate
    if (FLOPS_NOT_MEM != 0) begin : g_flops
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (w_doWrite && (r_wptr[c_AW-1:0] == c_AW'(i))) r_mem[i] <= i_wdata;
          end
        end
      end
    end else begin : g_mem
      always_ff @(posedge i_clk) begin
        if (w_doWrite) r_mem[r_wptr[c_AW-1:0]] <= i_wdata;
      end
    end
  endgenerate

  assign o_rdata = r_mem[r_rptr[c_AW-1:0]];

  assign w_count       = c_NW'(r_wptr - r_rptr);
  assign o_nEntries    = w_count;
  assign o_almostFull  = (w_count >= c_NW'(ALMOST_FULL));
  assign o_almostEmpty = (w_count <= c_NW'(ALMOST_EMPTY));

  a_no_write_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(w_doWrite && w_full));
  a_no_read_empty: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(w_doRead && w_empty));
  a_count_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (w_count <= c_NW'(DEPTH)));

endmodule
`default_nettype wire
